serial_frame_rx: RTL and testbench

- Framed serial receiver; the receive end of the serial link driven by the team's universal shift register.
- The transmitter side parallel-loads a byte, then shifts it out one bit per strobe. This block samples S_IN on each bit strobe, frames and deserialises the bits, and checks parity and stop.
- Presents each good word on a one-entry ready/valid output buffer, with error and overrun flags.

---
 rtl/serial_frame_rx.sv | 124 ++++++++++++
 tb/tb_serial_frame_rx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// serial_frame_rx
// Framed serial receiver for the shift-register serial link. It samples S_IN on
// each bit event (S_VALID & ENABLE), finds the start bit, and deserialises WIDTH
// data bits MSB- or LSB-first. It then checks an optional parity bit and the
// stop bit. Good words go to a one-entry ready/valid output buffer.
//
// Ports:
//   CLOCK, RESET        clock (rising edge), synchronous active-high reset
//   ENABLE              1 = sampling active, 0 = receive FSM frozen
//   S_IN, S_VALID       serial data line and its bit strobe
//   DIR                 0 = MSB first, 1 = LSB first (latched at the start bit)
//   Q, Q_VALID, Q_READY received word and its ready/valid handshake
//   FRAME_ERR, PAR_ERR  one-cycle error pulses (stop bit 0 / parity mismatch)
//   OVERRUN, CLR_OVR    sticky dropped-word flag and its synchronous clear
module serial_frame_rx #(
  parameter int WIDTH      = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             S_IN,
  input  logic             S_VALID,
  input  logic             DIR,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  input  logic             Q_READY,
  output logic             FRAME_ERR,
  output logic             PAR_ERR,
  output logic             OVERRUN,
  input  logic             CLR_OVR
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
  localparam logic           ODD  = (PARITY_ODD != 0);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [WIDTH-1:0] shift;
  logic [CW-1:0]    cnt;
  logic             dir_l;
  logic             par_mis;
  logic             bit_ev;
  logic             good_word;

  assign bit_ev    = S_VALID & ENABLE;
  // A stop bit of 1 with no parity mismatch completes a deliverable word.
  assign good_word = bit_ev && (state == STOP) && S_IN && !par_mis;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic d,
                                                input logic lsb_first);
    return lsb_first ? {d, cur[WIDTH-1:1]} : {cur[WIDTH-2:0], d};
  endfunction

  function automatic logic parity_bad(input logic [WIDTH-1:0] w, input logic p);
    return ((^w) ^ p) != ODD;
  endfunction

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= IDLE;
      shift     <= '0;
      cnt       <= '0;
      dir_l     <= 1'b0;
      par_mis   <= 1'b0;
      Q         <= '0;
      Q_VALID   <= 1'b0;
      FRAME_ERR <= 1'b0;
      PAR_ERR   <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      FRAME_ERR <= 1'b0;
      PAR_ERR   <= 1'b0;

      // Receive FSM: only advances on a bit event, so ENABLE=0 freezes it.
      if (bit_ev) begin
        case (state)
          IDLE: begin
            if (!S_IN) begin
              dir_l   <= DIR;
              shift   <= '0;
              cnt     <= '0;
              par_mis <= 1'b0;
              state   <= DATA;
            end
          end
          DATA: begin
            shift <= shift_in(shift, S_IN, dir_l);
            cnt   <= cnt + CW'(1);
            if (cnt == LAST) state <= (PARITY_EN != 0) ? PARITY : STOP;
          end
          PARITY: begin
            par_mis <= parity_bad(shift, S_IN);
            state   <= STOP;
          end
          STOP: begin
            // A bad stop bit masks any parity error on the same frame.
            if (!S_IN)        FRAME_ERR <= 1'b1;
            else if (par_mis) PAR_ERR   <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end

      // Output buffer: a same-cycle handshake frees the slot for a new word.
      if (good_word && (!Q_VALID || Q_READY)) begin
        Q       <= shift;
        Q_VALID <= 1'b1;
      end else if (Q_VALID && Q_READY) begin
        Q_VALID <= 1'b0;
      end

      // Setting the overrun flag wins over a same-cycle clear.
      if (good_word && Q_VALID && !Q_READY) OVERRUN <= 1'b1;
      else if (CLR_OVR)                     OVERRUN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Testbench for serial_frame_rx (WIDTH=8, even parity). Stimulus tasks push the
// expected word or error pulse into a scoreboard queue. A negedge monitor pops
// an entry whenever the DUT presents a new word or an error pulse. It compares
// the kind, the data and the cycle of arrival.
module tb_serial_frame_rx;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       ENABLE = 1'b1;
  logic       S_IN = 1'b1;
  logic       S_VALID = 1'b0;
  logic       DIR = 1'b0;
  logic       Q_READY = 1'b1;
  logic       CLR_OVR = 1'b0;
  logic [7:0] Q;
  logic       Q_VALID, FRAME_ERR, PAR_ERR, OVERRUN;

  serial_frame_rx #(.WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE), .S_IN(S_IN),
    .S_VALID(S_VALID), .DIR(DIR), .Q(Q), .Q_VALID(Q_VALID),
    .Q_READY(Q_READY), .FRAME_ERR(FRAME_ERR), .PAR_ERR(PAR_ERR),
    .OVERRUN(OVERRUN), .CLR_OVR(CLR_OVR)
  );

  always #5 CLOCK = ~CLOCK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  // kind: 0 = word, 1 = frame error, 2 = parity error
  typedef struct {
    int         kind;
    logic [7:0] q;
    int         due;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_cmp(input int kind, input logic [7:0] qv);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_output: kind %0d q %0h with nothing expected (cycle %0d)",
               kind, qv, cyc);
    end else begin
      e = sb.pop_front();
      check("out_kind", kind, e.kind);
      if (e.kind == 0) check("out_q", {24'h0, qv}, {24'h0, e.q});
      check("out_cycle", cyc, e.due);
    end
  endtask

  // Monitor: a word is newly presented when Q_VALID rises, or stays high right
  // after a handshake.
  logic prev_vld = 1'b0;
  logic prev_hs  = 1'b0;
  always @(negedge CLOCK) begin
    if (Q_VALID === 1'b1 && (!prev_vld || prev_hs)) pop_cmp(0, Q);
    if (FRAME_ERR === 1'b1) pop_cmp(1, 8'h00);
    if (PAR_ERR === 1'b1)   pop_cmp(2, 8'h00);
    prev_vld = (Q_VALID === 1'b1);
    prev_hs  = (Q_VALID === 1'b1) && Q_READY;
  end

  // Sends 11 strobes, v[10] first, with an idle cycle between strobes. DIR is
  // inverted right after the start bit, so the word only decodes correctly if
  // DIR was latched at the start bit. kind < 0 means nothing is expected.
  task automatic send_frame(input logic [10:0] v, input logic dir, input int kind,
                            input logic [7:0] q, input bit rdy_stop, input bit clr_stop,
                            input int freeze_at);
    for (int i = 0; i < 11; i++) begin
      if (i == freeze_at) begin
        ENABLE = 1'b0;
        for (int k = 0; k < 5; k++) begin
          S_VALID = ~k[0];
          S_IN    = k[1];
          @(posedge CLOCK); #1;
        end
        S_VALID = 1'b0;
        ENABLE  = 1'b1;
      end
      S_IN    = v[10-i];
      S_VALID = 1'b1;
      if (i == 0) DIR = dir;
      if (i == 1) DIR = ~dir;
      if (i == 10) begin
        if (rdy_stop) Q_READY = 1'b1;
        if (clr_stop) CLR_OVR = 1'b1;
      end
      @(posedge CLOCK); #1;
      S_VALID = 1'b0;
      CLR_OVR = 1'b0;
      if (i == 10 && kind >= 0) sb.push_back('{kind, q, cyc});
      @(posedge CLOCK); #1;
    end
    S_IN = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge CLOCK);
    #1 RESET = 1'b0;
    check("reset_q", Q, 0);
    check("reset_qvalid", Q_VALID, 0);
    check("reset_frame_err", FRAME_ERR, 0);
    check("reset_par_err", PAR_ERR, 0);
    check("reset_overrun", OVERRUN, 0);

    // MSB-first 0xA5, even parity bit 0, stop 1
    send_frame(11'b0_10100101_0_1, 1'b0, 0, 8'hA5, 1'b0, 1'b0, -1);
    // LSB-first 0x01 (back to back), parity bit 1, stop 1
    send_frame(11'b0_10000000_1_1, 1'b1, 0, 8'h01, 1'b0, 1'b0, -1);
    // Parity bit flipped -> PAR_ERR only
    send_frame(11'b0_10100101_1_1, 1'b0, 2, 8'h00, 1'b0, 1'b0, -1);
    check("qvalid_after_par_err", Q_VALID, 0);
    // Stop bit 0 with bad parity too -> FRAME_ERR only
    send_frame(11'b0_10100101_1_0, 1'b0, 1, 8'h00, 1'b0, 1'b0, -1);
    check("qvalid_after_frame_err", Q_VALID, 0);

    // Overrun: 0x11 held unconsumed, then 0x22 dropped with CLR_OVR in the same cycle
    Q_READY = 1'b0;
    send_frame(11'b0_00010001_0_1, 1'b0, 0, 8'h11, 1'b0, 1'b0, -1);
    send_frame(11'b0_00100010_0_1, 1'b0, -1, 8'h00, 1'b0, 1'b1, -1);
    check("ovr_q_held", Q, 8'h11);
    check("ovr_qvalid", Q_VALID, 1);
    check("ovr_set", OVERRUN, 1);
    CLR_OVR = 1'b1;
    @(posedge CLOCK); #1;
    CLR_OVR = 1'b0;
    check("ovr_cleared", OVERRUN, 0);

    // Simultaneous consume of 0x11 with arrival of 0x22
    send_frame(11'b0_00100010_0_1, 1'b0, 0, 8'h22, 1'b1, 1'b0, -1);
    check("sim_q", Q, 8'h22);
    check("sim_overrun", OVERRUN, 0);

    // ENABLE freeze mid-DATA, 0x3C MSB first
    send_frame(11'b0_00111100_0_1, 1'b0, 0, 8'h3C, 1'b0, 1'b0, 5);

    // Reset mid-frame: start plus three data bits, then reset
    for (int i = 0; i < 4; i++) begin
      S_IN = (i == 0) ? 1'b0 : 1'b1;
      S_VALID = 1'b1;
      @(posedge CLOCK); #1;
      S_VALID = 1'b0;
      @(posedge CLOCK); #1;
    end
    S_IN = 1'b1;
    RESET = 1'b1;
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    check("midrst_q", Q, 0);
    check("midrst_qvalid", Q_VALID, 0);
    check("midrst_overrun", OVERRUN, 0);
    check("midrst_frame_err", FRAME_ERR, 0);
    check("midrst_par_err", PAR_ERR, 0);
    // Full LSB-first 0xC3 after the reset
    send_frame(11'b0_11000011_0_1, 1'b1, 0, 8'hC3, 1'b0, 1'b0, -1);

    repeat (3) @(posedge CLOCK);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
